// File: rtl/alu_pkg.sv
// Shared opcode map and arbiter state encoding for the ALU sharing logic.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_MUL  = 4'h2;
    localparam logic [3:0] ALU_AND  = 4'h3;
    localparam logic [3:0] ALU_OR   = 4'h4;
    localparam logic [3:0] ALU_SLT  = 4'h5;
    localparam logic [3:0] ALU_SEQ  = 4'h6;
    localparam logic [3:0] ALU_SNE  = 4'h7;
    localparam logic [3:0] ALU_SRL  = 4'h8;
    localparam logic [3:0] ALU_SLL  = 4'h9;
    localparam logic [3:0] ALU_ROTR = 4'hA;
    localparam logic [3:0] ALU_CNTO = 4'hB;
    localparam logic [3:0] ALU_CNTZ = 4'hC;

    localparam logic [3:0] ALU_OP_MAX = ALU_CNTZ;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } arb_state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the two ALU clients and the arbiter.
interface alu_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned OP_WIDTH   = 4
);
    logic                  Req0, Req1;
    logic                  Ready0, Ready1;
    logic [DATA_WIDTH-1:0] A0, B0, A1, B1;
    logic [OP_WIDTH-1:0]   Op0, Op1;
    logic                  RspValid0, RspValid1;
    logic [DATA_WIDTH-1:0] RspData0, RspData1;
    logic                  RspZero0, RspZero1;
    logic                  RspErr0, RspErr1;
    logic                  RspAck0, RspAck1;
    logic                  Busy;

    modport master (
        output Req0, Req1, A0, B0, A1, B1, Op0, Op1, RspAck0, RspAck1,
        input  Ready0, Ready1, RspValid0, RspValid1, RspData0, RspData1,
        input  RspZero0, RspZero1, RspErr0, RspErr1, Busy
    );

    modport slave (
        input  Req0, Req1, A0, B0, A1, B1, Op0, Op1, RspAck0, RspAck1,
        output Ready0, Ready1, RspValid0, RspValid1, RspData0, RspData1,
        output RspZero0, RspZero1, RspErr0, RspErr1, Busy
    );
endinterface

// File: rtl/ALU32Bit.sv
// Combinational 32-bit ALU shared by the arbiter; Zero flags an all-zero result.
module ALU32Bit
    import alu_pkg::*;
(
    input  logic [3:0]  ALUControl,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] ALUResult,
    output logic        Zero
);
    logic [5:0]  ones;
    logic [4:0]  sh;
    logic [31:0] rot;

    assign sh  = B[4:0];
    // Shifting by 32 yields zero, so sh == 0 degenerates to A unchanged.
    assign rot = (A >> sh) | (A << (6'd32 - {1'b0, sh}));

    always_comb begin
        ones = 6'd0;
        for (int i = 0; i < 32; i++) begin
            ones = ones + {5'd0, A[i]};
        end
    end

    always_comb begin
        ALUResult = 32'd0;
        unique case (ALUControl)
            ALU_ADD:  ALUResult = A + B;
            ALU_SUB:  ALUResult = A - B;
            ALU_MUL:  ALUResult = A * B;
            ALU_AND:  ALUResult = A & B;
            ALU_OR:   ALUResult = A | B;
            ALU_SLT:  ALUResult = {31'd0, $signed(A) < $signed(B)};
            ALU_SEQ:  ALUResult = {31'd0, A == B};
            ALU_SNE:  ALUResult = {31'd0, A != B};
            ALU_SRL:  ALUResult = A >> sh;
            ALU_SLL:  ALUResult = A << sh;
            ALU_ROTR: ALUResult = rot;
            ALU_CNTO: ALUResult = {26'd0, ones};
            ALU_CNTZ: ALUResult = {26'd0, 6'd32 - ones};
            default:  ALUResult = 32'd0;
        endcase
    end

    assign Zero = (ALUResult == 32'd0);
endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU32Bit between two requesters, with a held
// response register per requester released by its acknowledge.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned         DATA_WIDTH = 32,
    parameter int unsigned         OP_WIDTH   = 4,
    parameter logic [OP_WIDTH-1:0] MAX_OP     = ALU_OP_MAX
) (
    input logic          Clk,
    input logic          Reset,
    alu_arbiter_if.slave bus
);
    arb_state_e            state_q, state_d;
    logic                  last_q, owner_q;
    logic [DATA_WIDTH-1:0] a_q, b_q;
    logic [OP_WIDTH-1:0]   op_q;
    logic [1:0]            rsp_valid_q, rsp_zero_q, rsp_err_q;
    logic [DATA_WIDTH-1:0] rsp_data_q [2];

    logic [1:0]            elig, gnt;
    logic                  illegal;
    logic [OP_WIDTH-1:0]   alu_ctrl;
    logic [DATA_WIDTH-1:0] alu_a, alu_b, alu_result;
    logic                  alu_zero;

    // A requester still holding an unacknowledged response may not be granted.
    assign elig = {bus.Req1 & ~rsp_valid_q[1], bus.Req0 & ~rsp_valid_q[0]};

    always_comb begin
        state_d = state_q;
        gnt     = 2'b00;
        unique case (state_q)
            IDLE: begin
                if (&elig) begin
                    gnt = last_q ? 2'b01 : 2'b10;
                end else begin
                    gnt = elig;
                end
                if (|gnt) begin
                    state_d = EXEC;
                end
            end
            EXEC: state_d = IDLE;
        endcase
    end

    assign illegal  = (op_q > MAX_OP);
    assign alu_ctrl = illegal ? '0 : op_q;
    assign alu_a    = illegal ? '0 : a_q;
    assign alu_b    = illegal ? '0 : b_q;

    ALU32Bit u_alu (
        .ALUControl(alu_ctrl),
        .A         (alu_a),
        .B         (alu_b),
        .ALUResult (alu_result),
        .Zero      (alu_zero)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q       <= IDLE;
            last_q        <= 1'b1;
            owner_q       <= 1'b0;
            a_q           <= '0;
            b_q           <= '0;
            op_q          <= '0;
            rsp_valid_q   <= '0;
            rsp_zero_q    <= '0;
            rsp_err_q     <= '0;
            rsp_data_q[0] <= '0;
            rsp_data_q[1] <= '0;
        end else begin
            state_q <= state_d;
            if (|gnt) begin
                owner_q <= gnt[1];
                last_q  <= gnt[1];
                a_q     <= gnt[1] ? bus.A1 : bus.A0;
                b_q     <= gnt[1] ? bus.B1 : bus.B0;
                op_q    <= gnt[1] ? bus.Op1 : bus.Op0;
            end
            if (bus.RspAck0) rsp_valid_q[0] <= 1'b0;
            if (bus.RspAck1) rsp_valid_q[1] <= 1'b0;
            if (state_q == EXEC) begin
                rsp_valid_q[owner_q] <= 1'b1;
                rsp_data_q[owner_q]  <= alu_result;
                rsp_zero_q[owner_q]  <= alu_zero;
                rsp_err_q[owner_q]   <= illegal;
            end
        end
    end

    assign bus.Ready0    = gnt[0];
    assign bus.Ready1    = gnt[1];
    assign bus.Busy      = (state_q == EXEC);
    assign bus.RspValid0 = rsp_valid_q[0];
    assign bus.RspValid1 = rsp_valid_q[1];
    assign bus.RspData0  = rsp_data_q[0];
    assign bus.RspData1  = rsp_data_q[1];
    assign bus.RspZero0  = rsp_zero_q[0];
    assign bus.RspZero1  = rsp_zero_q[1];
    assign bus.RspErr0   = rsp_err_q[0];
    assign bus.RspErr1   = rsp_err_q[1];
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed vector table, hand sequences and a random
// run scored against a transaction-level model of the arbiter and ALU.
module tb_alu_arbiter;
    import alu_pkg::*;

    typedef struct packed {
        logic [31:0] d;
        logic        z;
        logic        e;
    } res_t;

    typedef struct packed {
        logic        who;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] d;
        logic        z;
        logic        e;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_arbiter_if #(.DATA_WIDTH(32), .OP_WIDTH(4)) bus ();

    alu_arbiter #(.DATA_WIDTH(32), .OP_WIDTH(4), .MAX_OP(ALU_OP_MAX)) dut (
        .Clk  (clk),
        .Reset(rst_n),
        .bus  (bus)
    );

    int   total = 0;
    int   bad   = 0;
    int   due   [2];
    bit   hold  [2];
    bit   last_m;
    res_t pend  [2];
    res_t held  [2];
    int   grants[$];
    vec_t vecs  [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic res_t alu_ref(input logic [3:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
        res_t r;
        int   sh;
        sh = int'(b[4:0]);
        if (op > 4'hC) return '{d: 32'd0, z: 1'b1, e: 1'b1};
        case (op)
            4'h0: r.d = a + b;
            4'h1: r.d = a - b;
            4'h2: r.d = a * b;
            4'h3: r.d = a & b;
            4'h4: r.d = a | b;
            4'h5: r.d = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'h6: r.d = (a == b) ? 32'd1 : 32'd0;
            4'h7: r.d = (a != b) ? 32'd1 : 32'd0;
            4'h8: r.d = a >> sh;
            4'h9: r.d = a << sh;
            4'hA: for (int i = 0; i < 32; i++) r.d[i] = a[(i + sh) % 32];
            4'hB: r.d = $countones(a);
            default: r.d = 32 - $countones(a);
        endcase
        r.z = (r.d == 32'd0);
        r.e = 1'b0;
        return r;
    endfunction

    function automatic logic ready_of(input bit who);
        return who ? bus.Ready1 : bus.Ready0;
    endfunction
    function automatic logic valid_of(input bit who);
        return who ? bus.RspValid1 : bus.RspValid0;
    endfunction
    function automatic logic [31:0] data_of(input bit who);
        return who ? bus.RspData1 : bus.RspData0;
    endfunction
    function automatic logic zero_of(input bit who);
        return who ? bus.RspZero1 : bus.RspZero0;
    endfunction
    function automatic logic err_of(input bit who);
        return who ? bus.RspErr1 : bus.RspErr0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input bit who, input logic r, input logic [3:0] op,
                             input logic [31:0] a, input logic [31:0] b);
        if (who) begin
            bus.Req1 = r; bus.Op1 = op; bus.A1 = a; bus.B1 = b;
        end else begin
            bus.Req0 = r; bus.Op0 = op; bus.A0 = a; bus.B0 = b;
        end
    endtask

    task automatic set_ack(input bit who, input logic v);
        if (who) bus.RspAck1 = v;
        else bus.RspAck0 = v;
    endtask

    task automatic clear_inputs();
        drive_req(0, 0, 4'h0, 32'd0, 32'd0);
        drive_req(1, 0, 4'h0, 32'd0, 32'd0);
        set_ack(0, 0);
        set_ack(1, 0);
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int n = 0; n < 2; n++) begin
            due[n]  = 0;
            hold[n] = 1'b0;
        end
        last_m = 1'b1;
    endtask

    task automatic run_single(input string name, input bit who, input logic [3:0] op,
                              input logic [31:0] a, input logic [31:0] b, input res_t exp);
        drive_req(who, 1, op, a, b);
        #1;
        check({name, "_ready"}, ready_of(who), 1);
        check({name, "_ready_other"}, ready_of(!who), 0);
        tick();
        // Scramble operands after the handshake; the in-flight op must ignore them.
        drive_req(who, 0, 4'h1, 32'hDEAD_BEEF, 32'h1234_5678);
        check({name, "_busy"}, bus.Busy, 1);
        check({name, "_early_valid"}, valid_of(who), 0);
        tick();
        check({name, "_valid"}, valid_of(who), 1);
        check({name, "_data"}, data_of(who), exp.d);
        check({name, "_zero"}, zero_of(who), exp.z);
        check({name, "_err"}, err_of(who), exp.e);
        tick();
        check({name, "_hold"}, valid_of(who), 1);
        check({name, "_hold_data"}, data_of(who), exp.d);
        set_ack(who, 1);
        tick();
        set_ack(who, 0);
        check({name, "_released"}, valid_of(who), 0);
    endtask

    // mode 0: random traffic, 1: both always requesting with same-cycle acks, 2: drain.
    task automatic model_cycle(input int mode);
        bit          exec_m;
        bit   [1:0]  req, ack, elig, gexp;
        logic [3:0]  op [2];
        logic [31:0] a  [2];
        logic [31:0] b  [2];
        exec_m = (due[0] == 2) || (due[1] == 2);
        for (int n = 0; n < 2; n++) begin
            if (due[n] == 1) begin
                check($sformatf("rnd_valid%0d", n), valid_of(n[0]), 1);
                check($sformatf("rnd_data%0d", n), data_of(n[0]), pend[n].d);
                check($sformatf("rnd_zero%0d", n), zero_of(n[0]), pend[n].z);
                check($sformatf("rnd_err%0d", n), err_of(n[0]), pend[n].e);
                held[n] = pend[n];
                hold[n] = 1'b1;
                due[n]  = 0;
            end else begin
                if (hold[n]) begin
                    check($sformatf("rnd_hold%0d", n), valid_of(n[0]), 1);
                    check($sformatf("rnd_hold_data%0d", n), data_of(n[0]), held[n].d);
                end else begin
                    check($sformatf("rnd_novalid%0d", n), valid_of(n[0]), 0);
                end
                if (due[n] == 2) due[n] = 1;
            end
        end
        check("rnd_busy", bus.Busy, exec_m);
        for (int n = 0; n < 2; n++) begin
            req[n] = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : ($urandom_range(0, 2) != 0);
            ack[n] = (mode == 0) ? $urandom_range(0, 1) : hold[n];
            op[n]  = 4'($urandom_range(0, 15));
            a[n]   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
            b[n]   = ($urandom_range(0, 3) == 0) ? a[n] : $urandom;
            elig[n] = req[n] & ~hold[n];
            if (ack[n]) hold[n] = 1'b0;
            drive_req(n[0], req[n], op[n], a[n], b[n]);
            set_ack(n[0], ack[n]);
        end
        #1;
        gexp = 2'b00;
        if (!exec_m) gexp = (elig == 2'b11) ? (last_m ? 2'b01 : 2'b10) : elig;
        check("rnd_ready0", bus.Ready0, gexp[0]);
        check("rnd_ready1", bus.Ready1, gexp[1]);
        for (int n = 0; n < 2; n++) begin
            if (gexp[n]) begin
                pend[n] = alu_ref(op[n], a[n], b[n]);
                due[n]  = 2;
                last_m  = n[0];
                grants.push_back(n);
            end
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1'b0, ALU_ADD,  32'h3E8,      32'h112,  32'h4FA,      1'b0, 1'b0};
        vecs[1]  = '{1'b1, ALU_SUB,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,    1'b1, 1'b0};
        vecs[2]  = '{1'b0, 4'hE,     32'h123,      32'h456,  32'h0,        1'b1, 1'b1};
        vecs[3]  = '{1'b1, ALU_CNTO, 32'hFFFFFFF1, 32'h0,    32'd29,       1'b0, 1'b0};
        vecs[4]  = '{1'b0, ALU_CNTZ, 32'hF0000000, 32'h0,    32'd28,       1'b0, 1'b0};
        vecs[5]  = '{1'b1, ALU_SLT,  32'hFFFFFFFF, 32'h1,    32'h1,        1'b0, 1'b0};
        vecs[6]  = '{1'b0, ALU_SNE,  32'h5,        32'h5,    32'h0,        1'b1, 1'b0};
        vecs[7]  = '{1'b1, ALU_SRL,  32'h80000000, 32'h4,    32'h08000000, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, ALU_SLL,  32'h1,        32'd31,   32'h80000000, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, ALU_AND,  32'hF0F0,     32'hFF00, 32'hF000,     1'b0, 1'b0};
        vecs[10] = '{1'b0, ALU_MUL,  32'h3E8,      32'h112,  32'h00042E50, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 4'hF,     32'hAAAA,     32'h5555, 32'h0,        1'b1, 1'b1};
        vecs[12] = '{1'b0, ALU_SEQ,  32'h7,        32'h7,    32'h1,        1'b0, 1'b0};
        vecs[13] = '{1'b1, ALU_OR,   32'hF0,       32'h0F,   32'hFF,       1'b0, 1'b0};

        clear_inputs();
        rst_n = 1'b0;
        #1;
        check("reset_valid0", bus.RspValid0, 0);
        check("reset_valid1", bus.RspValid1, 0);
        check("reset_busy", bus.Busy, 0);
        check("reset_data0", bus.RspData0, 0);
        do_reset();
        check("reset_ready0", bus.Ready0, 0);
        check("reset_err1", bus.RspErr1, 0);

        foreach (vecs[i]) begin
            run_single($sformatf("vec%0d", i), vecs[i].who, vecs[i].op, vecs[i].a, vecs[i].b,
                       '{d: vecs[i].d, z: vecs[i].z, e: vecs[i].e});
        end

        // Simultaneous requests straight out of reset: requester 0 first.
        do_reset();
        drive_req(0, 1, ALU_MUL, 32'h3E8, 32'h112);
        drive_req(1, 1, ALU_ROTR, 32'hFED, 32'h1);
        #1;
        check("sim_ready0", bus.Ready0, 1);
        check("sim_ready1_lost", bus.Ready1, 0);
        tick();
        drive_req(0, 0, 4'h0, 32'd0, 32'd0);
        check("sim_exec_ready1", bus.Ready1, 0);
        tick();
        check("sim_valid0", bus.RspValid0, 1);
        check("sim_data0", bus.RspData0, 32'h00042E50);
        check("sim_valid1_pending", bus.RspValid1, 0);
        check("sim_ready1", bus.Ready1, 1);
        tick();
        drive_req(1, 0, 4'h0, 32'd0, 32'd0);
        tick();
        check("sim_valid1", bus.RspValid1, 1);
        check("sim_data1", bus.RspData1, 32'h800007F6);
        check("sim_keep_valid0", bus.RspValid0, 1);
        check("sim_keep_data0", bus.RspData0, 32'h00042E50);

        // Unacked response on requester 1 blocks its new request.
        set_ack(0, 1);
        drive_req(1, 1, ALU_CNTO, 32'hFFFFFFF1, 32'd0);
        #1;
        check("blk_ready1", bus.Ready1, 0);
        tick();
        set_ack(0, 0);
        check("blk_valid0_cleared", bus.RspValid0, 0);
        check("blk_ready1_still", bus.Ready1, 0);
        check("blk_valid1", bus.RspValid1, 1);
        check("blk_data1", bus.RspData1, 32'h800007F6);
        set_ack(1, 1);
        #1;
        check("blk_ready1_on_ack", bus.Ready1, 0);
        tick();
        set_ack(1, 0);
        check("blk_valid1_cleared", bus.RspValid1, 0);
        check("blk_ready1_after_ack", bus.Ready1, 1);
        tick();
        drive_req(1, 0, 4'h0, 32'd0, 32'd0);
        tick();
        check("blk_cnto_valid", bus.RspValid1, 1);
        check("blk_cnto_data", bus.RspData1, 32'd29);

        // Sustained contention with same-cycle acks: grants must alternate.
        do_reset();
        grants.delete();
        for (int c = 0; c < 80 && grants.size() < 16; c++) model_cycle(1);
        check("cont_grant_count", (grants.size() >= 16) ? 32'd1 : 32'd0, 1);
        for (int k = 0; k < 16 && k < grants.size(); k++) begin
            check($sformatf("cont_order%0d", k), grants[k], k % 2);
        end

        // The last grant is in flight: reset during EXEC drops it.
        clear_inputs();
        check("rst_mid_busy", bus.Busy, 1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy0", bus.Busy, 0);
        check("rst_mid_valid0", bus.RspValid0, 0);
        check("rst_mid_valid1", bus.RspValid1, 0);
        check("rst_mid_data0", bus.RspData0, 0);
        check("rst_mid_data1", bus.RspData1, 0);
        do_reset();
        tick();
        check("rst_post_valid0", bus.RspValid0, 0);
        check("rst_post_valid1", bus.RspValid1, 0);
        drive_req(0, 1, ALU_ADD, 32'd1, 32'd2);
        drive_req(1, 1, ALU_ADD, 32'd3, 32'd4);
        #1;
        check("rst_post_prio0", bus.Ready0, 1);
        check("rst_post_prio1", bus.Ready1, 0);

        do_reset();
        repeat (400) model_cycle(0);
        repeat (4) model_cycle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Two-requester round-robin arbiter and sequencer that shares a single ALU32Bit instance between independent clients, for example the execute stage and a multi-cycle helper unit.
- Accepts one operation at a time through a valid/ready handshake.
- Registers the operands and opcode, drives them into the ALU, and captures ALUResult/Zero into a per-requester response holding register.
- Each response register is released by a response acknowledge.
- Sits between the requesters and the existing ALU32Bit, which it instantiates unchanged.

Parameters:
DATA_WIDTH, 32, operand/result width (must match ALU32Bit).
OP_WIDTH, 4, ALU control width.
MAX_OP, 4'hC, highest legal opcode (COUNT ZEROS); opcodes above it are illegal.

Ports:
Clk  in  1  system clock, rising edge.
Reset  in  1  asynchronous, active-low reset.
Req0, Req1  in  1  request valid, requester 0/1.
Ready0, Ready1  out  1  request accepted this cycle (handshake = Reqn & Readyn).
A0, B0, A1, B1  in  DATA_WIDTH  operands per requester.
Op0, Op1  in  OP_WIDTH  ALUControl code per requester.
RspValid0, RspValid1  out  1  result held for requester n.
RspData0, RspData1  out  DATA_WIDTH  captured ALUResult.
RspZero0, RspZero1  out  1  captured Zero.
RspErr0, RspErr1  out  1  opcode was illegal.
RspAck0, RspAck1  in  1  requester n consumes its response.
Busy  out  1  FSM in EXEC.

Behaviour:
- Reset (async, Reset=0): FSM=IDLE, Last=1 (requester 0 wins first), all RspValid/RspData/RspZero/RspErr=0, operand/op/owner registers=0, Ready0/1=0, Busy=0. Reset mid-operation discards the in-flight op; no response is produced.
- Eligibility: Elign = Reqn & ~RspValidn, using the registered RspValid. A requester with an unacknowledged response is never granted.
- FSM IDLE:
  - Readyn is combinational and asserted only in IDLE, for exactly one eligible requester.
  - If both are eligible, grant the one not equal to Last; if one is eligible, grant it.
  - On grant: latch An, Bn, Opn and Owner=n; set Last=n; go to EXEC.
  - No grant: stay in IDLE.
- FSM EXEC:
  - Busy=1; Ready0/1=0.
  - ALU32Bit is driven from the latched registers only, never directly from the request ports.
  - At the clock edge ending EXEC: RspData[Owner]<=ALUResult, RspZero[Owner]<=Zero, RspErr[Owner]<=0, RspValid[Owner]<=1; go to IDLE.
- Illegal opcode (Op > MAX_OP):
  - Still granted and still takes EXEC.
  - ALU control is forced to 4'b0000 with A=B=0.
  - Captures RspData=0, RspZero=1, RspErr=1.
- Latency: handshake at edge t, RspValid high after edge t+1. Throughput is at most one op per 2 cycles.
- Response hold: RspValidn and its data stay stable until a cycle with RspAckn=1; RspValidn clears at that edge. RspAckn while RspValidn=0 is ignored.
- Simultaneous events:
  - Ack and re-request in the same cycle: the request is not eligible that cycle; earliest grant is next cycle.
  - Capture into one requester never disturbs the other requester's held response.
- Changes on Reqn/An/Bn/Opn after the handshake have no effect on the in-flight op.
- Fairness: under continuous requests from both, grants strictly alternate 0,1,0,1, provided responses are acked within one cycle.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams ALU_ADD=0 through ALU_CNTZ=4'hC: ADD, SUB, MUL, AND, OR, SLT, SEQ, SNE, SRL, SLL, ROTR, CNTO, CNTZ.
  - ALU_OP_MAX.
  - FSM state encodings IDLE=1'b0, EXEC=1'b1.
- Sub-module: the existing ALU32Bit, instantiated once. Arbitration and the FSM stay in the top file; no further split.

Test Plan:
- Single request on requester 0: A0=0x3E8, B0=0x112, Op0=ADD; Ready0 pulses once; two edges later RspValid0=1, RspData0=0x4FA, RspZero0=0; holds until RspAck0.
- Simultaneous Req0/Req1 from reset:
  - Req0 is MUL 0x3E8*0x112; Req1 is ROTR 0xFED by 1.
  - Requester 0 is granted first, giving RspData0=0x00042E50.
  - Requester 1 is granted next, giving RspData1=0x800007F6.
- Unacked response blocks: RspValid1 held, Req1 re-asserted with CNTO A1=0xFFFFFFF1 -> no Ready1. After RspAck1 -> granted next cycle, RspData1=29.
- Zero flag and illegal op: SUB 0xFFFFFFFF-0xFFFFFFFF -> RspData=0, RspZero=1, RspErr=0. Op=4'hE -> RspData=0, RspZero=1, RspErr=1.
- Reset mid-EXEC: Reset=0 asserted during EXEC -> all outputs 0 immediately (async). After release, no stale RspValid, and requester 0 has priority.
- Sustained contention: 8 back-to-back requests per side, acks returned same cycle -> grants alternate 0,1,0,1, and every result matches the ALU reference model.
